// File: rtl/tt_check_pkg.sv
// Shared definitions for the truth-table checker: FSM encoding, default
// table and settle-counter width.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit m holds the expected gate output for minterm m (2-input NOR).
  localparam logic [3:0] NOR_TABLE = 4'b0001;

  localparam int CNT_W = 4;

endpackage

// File: rtl/minterm_sequencer.sv
// Minterm index and settle counter for the checker sweep; the FSM in the
// top decides when to clear, step the settle count, or move to the next minterm.
import tt_check_pkg::*;

module minterm_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            step,
  input  logic            next,
  output logic [N_IN-1:0] m,
  output logic            last_minterm,
  output logic            settled
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '0;
      cnt <= '0;
    end else if (clear) begin
      m   <= '0;
      cnt <= '0;
    end else if (next) begin
      m   <= m + N_IN'(1);
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last_minterm = (m == '1);
  assign settled      = (cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every minterm into two gate implementations, samples both after a
// settle window and scores them against the EXPECT truth table.
import tt_check_pkg::*;

module truth_table_checker #(
  parameter int                    N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = NOR_TABLE,
  parameter int                    SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] x,
  input  logic            s_a,
  input  logic            s_b,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_bad,
  output logic            bad_valid,
  output logic [1:0]      fsm_state
);

  state_t          state, state_nxt;
  logic            seq_clear, seq_step, seq_next;
  logic            check_en, clr_results;
  logic [N_IN-1:0] m;
  logic            last_minterm, settled;
  logic            mismatch;

  minterm_sequencer #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (seq_clear),
    .step         (seq_step),
    .next         (seq_next),
    .m            (m),
    .last_minterm (last_minterm),
    .settled      (settled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    seq_clear   = 1'b0;
    seq_step    = 1'b0;
    seq_next    = 1'b0;
    check_en    = 1'b0;
    clr_results = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt   = DRIVE;
          seq_clear   = 1'b1;
          clr_results = 1'b1;
        end
      end
      DRIVE: begin
        seq_step = 1'b1;
        if (settled) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        check_en = 1'b1;
        if (last_minterm) begin
          state_nxt = DONE;
        end else begin
          seq_next  = 1'b1;
          state_nxt = DRIVE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One mismatch per minterm, even when both implementations are wrong.
  assign mismatch = (s_a != EXPECT[m]) | (s_b != EXPECT[m]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt   <= '0;
      first_bad <= '0;
      bad_valid <= 1'b0;
    end else if (clr_results) begin
      err_cnt   <= '0;
      first_bad <= '0;
      bad_valid <= 1'b0;
    end else if (check_en && mismatch) begin
      err_cnt <= err_cnt + (N_IN+1)'(1);
      if (!bad_valid) begin
        first_bad <= m;
        bad_valid <= 1'b1;
      end
    end
  end

  assign x         = (state == IDLE) ? '0 : m;
  assign busy      = (state == DRIVE) || (state == SAMPLE);
  assign done      = (state == DONE);
  assign pass      = done && (err_cnt == '0);
  assign fsm_state = state;

endmodule
